// File: rtl/pong_pkg.sv
// Shared definitions for the ping-pong match controller.
// Holds the game state codes, the winner codes and the serve-mode selectors.
// The state and winner codes are also what the VGA and scoreboard logic decode.
package pong_pkg;

  // State codes are visible on the game_state output, so the values are fixed.
  typedef enum logic [2:0] {
    SERVE_P1    = 3'd0,
    SERVE_P2    = 3'd1,
    PLAYING     = 3'd2,
    GAME_END    = 3'd3,
    POINT_PAUSE = 3'd4
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  // Who serves after a point has been scored.
  localparam int SERVE_LOSER  = 0;
  localparam int SERVE_WINNER = 1;

endpackage

// File: rtl/hold_timer.sv
// Load-and-count-down timer used for the pause after each point.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load_i     : reload the counter with CYCLES-1 (has priority over counting)
//   en_i       : count down by one per cycle while nonzero
//   zero_o     : high while the counter holds zero
// Loading CYCLES-1 and exiting on the zero cycle gives a hold of exactly
// CYCLES cycles, counting the cycle right after the load.
module hold_timer #(
  parameter int CYCLES = 4,
  parameter int W      = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload on request, otherwise step down until zero and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Match controller for the ping-pong game: serve, play, scoring, post-point
// pause, win-by-margin / saturation win and time-limit ending.
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   p1l, p1r, p2l, p2r     : player buttons (level)
//   ball_x                 : ball horizontal position
//   time_cnt               : elapsed match seconds
//   game_state             : registered state code (see pong_pkg)
//   p1_score, p2_score     : registered scores, saturating
//   winner                 : 0 none, 1 P1, 2 P2, 3 draw
//   point_p1, point_p2     : one-cycle pulse when a point is awarded
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int X_W          = 10,
  parameter int SCORE_W      = 4,
  parameter int TIME_W       = 6,
  parameter int GOAL_POINTS  = 7,
  parameter int WIN_BY       = 2,
  parameter int GAME_TIME    = 60,
  parameter int P1_BOARD_X   = 150,
  parameter int P2_BOARD_X   = 490,
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int SERVE_MODE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p1l,
  input  logic               p1r,
  input  logic               p2l,
  input  logic               p2r,
  input  logic [X_W-1:0]     ball_x,
  input  logic [TIME_W-1:0]  time_cnt,
  output logic [2:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         winner,
  output logic               point_p1,
  output logic               point_p2
);

  localparam int SW1 = SCORE_W + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SW1-1:0]     GOAL_EXT  = SW1'(GOAL_POINTS);
  localparam logic [SW1-1:0]     LEAD_EXT  = SW1'(WIN_BY);
  localparam logic [X_W-1:0]     P1_BOARD  = X_W'(P1_BOARD_X);
  localparam logic [X_W-1:0]     P2_BOARD  = X_W'(P2_BOARD_X);
  localparam logic [TIME_W:0]    TIME_EXT  = (TIME_W + 1)'(GAME_TIME);
  localparam logic               LOSER_SERVES = (SERVE_MODE == SERVE_LOSER);

  game_state_e        state_q, state_d;
  logic [SCORE_W-1:0] p1Score_q, p1Score_d;
  logic [SCORE_W-1:0] p2Score_q, p2Score_d;
  winner_e            winner_q, winner_d;
  logic               pointP1_q, pointP1_d;
  logic               pointP2_q, pointP2_d;
  logic               serverP2_q, serverP2_d;

  logic               timerLoad;
  logic               timerEn;
  logic               timerZero;
  logic               timeout;
  logic [SW1-1:0]     p1Ext, p2Ext;
  logic               p1Wins, p2Wins;
  winner_e            scoreWinner;

  hold_timer #(
    .CYCLES(PAUSE_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .load_i(timerLoad),
    .en_i  (timerEn),
    .zero_o(timerZero)
  );

  // Widen by one bit so the timeout threshold may sit at the top of the range.
  assign timeout = ({1'b0, time_cnt} >= TIME_EXT);

  // Scores are widened by one bit for the lead arithmetic; the subtraction is
  // only trusted after the ordering check, so it is always non-negative.
  // A saturated score ends the match on its own, whatever the lead.
  assign p1Ext  = {1'b0, p1Score_q};
  assign p2Ext  = {1'b0, p2Score_q};
  assign p1Wins = ((p1Ext >= GOAL_EXT) && (p1Ext >= p2Ext) && ((p1Ext - p2Ext) >= LEAD_EXT))
                  || (p1Score_q == SCORE_MAX);
  assign p2Wins = ((p2Ext >= GOAL_EXT) && (p2Ext >= p1Ext) && ((p2Ext - p1Ext) >= LEAD_EXT))
                  || (p2Score_q == SCORE_MAX);

  // Winner when the clock runs out: straight score comparison.
  assign scoreWinner = (p1Ext > p2Ext) ? WIN_P1 :
                       (p2Ext > p1Ext) ? WIN_P2 : WIN_DRAW;

  assign timerEn = (state_q == POINT_PAUSE);

  // Next-state logic. A goal in PLAYING beats a simultaneous timeout; the
  // timeout is looked at again when the pause expires, after the win check.
  always_comb begin
    state_d    = state_q;
    p1Score_d  = p1Score_q;
    p2Score_d  = p2Score_q;
    winner_d   = winner_q;
    serverP2_d = serverP2_q;
    pointP1_d  = 1'b0;
    pointP2_d  = 1'b0;
    timerLoad  = 1'b0;

    case (state_q)
      SERVE_P1: begin
        if (timeout) begin
          state_d  = GAME_END;
          winner_d = scoreWinner;
        end else if (p1l || p1r) begin
          state_d = PLAYING;
        end
      end

      SERVE_P2: begin
        if (timeout) begin
          state_d  = GAME_END;
          winner_d = scoreWinner;
        end else if (p2l || p2r) begin
          state_d = PLAYING;
        end
      end

      PLAYING: begin
        if (ball_x > P2_BOARD) begin
          p1Score_d  = (p1Score_q == SCORE_MAX) ? p1Score_q : p1Score_q + 1'b1;
          pointP1_d  = 1'b1;
          serverP2_d = LOSER_SERVES;
          timerLoad  = 1'b1;
          state_d    = POINT_PAUSE;
        end else if (ball_x < P1_BOARD) begin
          p2Score_d  = (p2Score_q == SCORE_MAX) ? p2Score_q : p2Score_q + 1'b1;
          pointP2_d  = 1'b1;
          serverP2_d = !LOSER_SERVES;
          timerLoad  = 1'b1;
          state_d    = POINT_PAUSE;
        end else if (timeout) begin
          state_d  = GAME_END;
          winner_d = scoreWinner;
        end
      end

      POINT_PAUSE: begin
        if (timerZero) begin
          if (p1Wins) begin
            state_d  = GAME_END;
            winner_d = WIN_P1;
          end else if (p2Wins) begin
            state_d  = GAME_END;
            winner_d = WIN_P2;
          end else if (timeout) begin
            state_d  = GAME_END;
            winner_d = scoreWinner;
          end else begin
            state_d = serverP2_q ? SERVE_P2 : SERVE_P1;
          end
        end
      end

      GAME_END: begin
        state_d = GAME_END;
      end

      default: begin
        state_d = SERVE_P1;
      end
    endcase
  end

  // State, score and output registers; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SERVE_P1;
      p1Score_q  <= '0;
      p2Score_q  <= '0;
      winner_q   <= WIN_NONE;
      pointP1_q  <= 1'b0;
      pointP2_q  <= 1'b0;
      serverP2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1Score_q  <= p1Score_d;
      p2Score_q  <= p2Score_d;
      winner_q   <= winner_d;
      pointP1_q  <= pointP1_d;
      pointP2_q  <= pointP2_d;
      serverP2_q <= serverP2_d;
    end
  end

  assign game_state = state_q;
  assign p1_score   = p1Score_q;
  assign p2_score   = p2Score_q;
  assign winner     = winner_q;
  assign point_p1   = pointP1_q;
  assign point_p2   = pointP2_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl.
// Two instances: dut 0 uses 4-bit scores with loser-serves, dut 1 uses 3-bit
// scores (saturation at 7) with winner-serves. Both pause 4 cycles per point.
// Expected values are queued when stimulus is driven and compared one cycle
// later, just after the clock edge that consumed the stimulus.
module tb_pong_match_ctrl;

  localparam int S_SP1   = 0;
  localparam int S_SP2   = 1;
  localparam int S_PLAY  = 2;
  localparam int S_END   = 3;
  localparam int S_PAUSE = 4;

  // Button vectors ordered {p1l, p1r, p2l, p2r}.
  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] P1L  = 4'b1000;
  localparam logic [3:0] P1R  = 4'b0100;
  localparam logic [3:0] P2L  = 4'b0010;
  localparam logic [3:0] P2R  = 4'b0001;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [9:0] bx;
    logic [5:0] tc;
    int         st;
    int         s1;
    int         s2;
    int         win;
    int         pt1;
    int         pt2;
  } vec_t;

  typedef struct {
    int   d;
    vec_t v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstV  [2];
  logic       p1lV  [2];
  logic       p1rV  [2];
  logic       p2lV  [2];
  logic       p2rV  [2];
  logic [9:0] ballV [2];
  logic [5:0] timeV [2];

  logic [2:0] aState, bState;
  logic [3:0] aS1, aS2;
  logic [2:0] bS1, bS2;
  logic [1:0] aWin, bWin;
  logic       aPt1, aPt2, bPt1, bPt2;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   eS1 [2];
  int   eS2 [2];
  vec_t tbl [17];

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .X_W(10), .SCORE_W(4), .TIME_W(6), .GOAL_POINTS(7), .WIN_BY(2),
    .GAME_TIME(60), .P1_BOARD_X(150), .P2_BOARD_X(490),
    .PAUSE_CYCLES(4), .SERVE_MODE(0)
  ) dutA (
    .clk(clk), .reset(rstV[0]),
    .p1l(p1lV[0]), .p1r(p1rV[0]), .p2l(p2lV[0]), .p2r(p2rV[0]),
    .ball_x(ballV[0]), .time_cnt(timeV[0]),
    .game_state(aState), .p1_score(aS1), .p2_score(aS2), .winner(aWin),
    .point_p1(aPt1), .point_p2(aPt2)
  );

  pong_match_ctrl #(
    .X_W(10), .SCORE_W(3), .TIME_W(6), .GOAL_POINTS(7), .WIN_BY(2),
    .GAME_TIME(60), .P1_BOARD_X(150), .P2_BOARD_X(490),
    .PAUSE_CYCLES(4), .SERVE_MODE(1)
  ) dutB (
    .clk(clk), .reset(rstV[1]),
    .p1l(p1lV[1]), .p1r(p1rV[1]), .p2l(p2lV[1]), .p2r(p2rV[1]),
    .ball_x(ballV[1]), .time_cnt(timeV[1]),
    .game_state(bState), .p1_score(bS1), .p2_score(bS2), .winner(bWin),
    .point_p1(bPt1), .point_p2(bPt2)
  );

  task automatic cmp(input string name, input int d, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s dut%0d t=%0t: got %0d, expected %0d", name, d, $time, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty t=%0t: got 0 entries, expected 1", $time);
      return;
    end
    e = sbq.pop_front();
    if (e.d == 0) begin
      cmp("state",  0, int'(aState), e.v.st);
      cmp("p1scr",  0, int'(aS1),    e.v.s1);
      cmp("p2scr",  0, int'(aS2),    e.v.s2);
      cmp("winner", 0, int'(aWin),   e.v.win);
      cmp("pulse1", 0, int'(aPt1),   e.v.pt1);
      cmp("pulse2", 0, int'(aPt2),   e.v.pt2);
    end else begin
      cmp("state",  1, int'(bState), e.v.st);
      cmp("p1scr",  1, int'(bS1),    e.v.s1);
      cmp("p2scr",  1, int'(bS2),    e.v.s2);
      cmp("winner", 1, int'(bWin),   e.v.win);
      cmp("pulse1", 1, int'(bPt1),   e.v.pt1);
      cmp("pulse2", 1, int'(bPt2),   e.v.pt2);
    end
  endtask

  task automatic applyStimulus(input int d, input vec_t v);
    exp_t e;
    rstV[d]  = v.rst;
    p1lV[d]  = v.btn[3];
    p1rV[d]  = v.btn[2];
    p2lV[d]  = v.btn[1];
    p2rV[d]  = v.btn[0];
    ballV[d] = v.bx;
    timeV[d] = v.tc;
    e.d = d;
    e.v = v;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic step(input int d, input logic rst, input logic [3:0] btn,
                      input logic [9:0] bx, input logic [5:0] tc,
                      input int st, input int s1, input int s2,
                      input int win, input int pt1, input int pt2);
    vec_t v;
    v.rst = rst; v.btn = btn; v.bx = bx; v.tc = tc;
    v.st = st; v.s1 = s1; v.s2 = s2; v.win = win; v.pt1 = pt1; v.pt2 = pt2;
    applyStimulus(d, v);
  endtask

  task automatic resetDut(input int d);
    eS1[d] = 0;
    eS2[d] = 0;
    step(d, 1'b1, NONE, 10'd320, 6'd0, S_SP1, 0, 0, 0, 0, 0);
  endtask

  // Serve, score one point, sit through the 4-cycle pause, check where it lands.
  task automatic point(input int d, input logic [3:0] serveBtn, input bit p1Scores,
                       input logic [5:0] tc, input int afterSt, input int afterWin);
    logic [9:0] bx;
    int         maxS;
    maxS = (d == 0) ? 15 : 7;
    bx   = p1Scores ? 10'd500 : 10'd100;
    step(d, 1'b0, serveBtn, 10'd320, 6'd0, S_PLAY, eS1[d], eS2[d], 0, 0, 0);
    if (p1Scores) eS1[d] = (eS1[d] + 1 > maxS) ? maxS : eS1[d] + 1;
    else          eS2[d] = (eS2[d] + 1 > maxS) ? maxS : eS2[d] + 1;
    step(d, 1'b0, NONE, bx, tc, S_PAUSE, eS1[d], eS2[d], 0, p1Scores ? 1 : 0, p1Scores ? 0 : 1);
    repeat (3) step(d, 1'b0, NONE, bx, tc, S_PAUSE, eS1[d], eS2[d], 0, 0, 0);
    step(d, 1'b0, NONE, bx, tc, afterSt, eS1[d], eS2[d], afterWin, 0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rstV[i] = 1'b1; p1lV[i] = 1'b0; p1rV[i] = 1'b0; p2lV[i] = 1'b0;
      p2rV[i] = 1'b0; ballV[i] = 10'd320; timeV[i] = 6'd0;
    end

    // Basic point for P1 then a point for P2, loser serves.
    tbl[0]  = '{1'b1, 4'b0000, 10'd320, 6'd0, S_SP1,   0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 4'b0011, 10'd320, 6'd0, S_SP1,   0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 4'b1000, 10'd320, 6'd0, S_PLAY,  0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 4'b0000, 10'd490, 6'd0, S_PLAY,  0, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 4'b0000, 10'd150, 6'd0, S_PLAY,  0, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 4'b0000, 10'd500, 6'd0, S_PAUSE, 1, 0, 0, 1, 0};
    tbl[6]  = '{1'b0, 4'b1000, 10'd500, 6'd0, S_PAUSE, 1, 0, 0, 0, 0};
    tbl[7]  = '{1'b0, 4'b1000, 10'd500, 6'd0, S_PAUSE, 1, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, 4'b1000, 10'd500, 6'd0, S_PAUSE, 1, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, 4'b1000, 10'd500, 6'd0, S_SP2,   1, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 4'b1000, 10'd320, 6'd0, S_SP2,   1, 0, 0, 0, 0};
    tbl[11] = '{1'b0, 4'b0001, 10'd320, 6'd0, S_PLAY,  1, 0, 0, 0, 0};
    tbl[12] = '{1'b0, 4'b0000, 10'd100, 6'd0, S_PAUSE, 1, 1, 0, 0, 1};
    tbl[13] = '{1'b0, 4'b0000, 10'd100, 6'd0, S_PAUSE, 1, 1, 0, 0, 0};
    tbl[14] = '{1'b0, 4'b0000, 10'd100, 6'd0, S_PAUSE, 1, 1, 0, 0, 0};
    tbl[15] = '{1'b0, 4'b0000, 10'd100, 6'd0, S_PAUSE, 1, 1, 0, 0, 0};
    tbl[16] = '{1'b0, 4'b0000, 10'd100, 6'd0, S_SP1,   1, 1, 0, 0, 0};

    $display("[TB] table vectors on dut0");
    for (int i = 0; i < 17; i++) applyStimulus(0, tbl[i]);
    eS1[0] = 1;
    eS2[0] = 1;

    $display("[TB] win-by-two on dut0");
    for (int k = 2; k <= 6; k++) begin
      point(0, P1L, 1'b1, 6'd0, S_SP2, 0);
      point(0, P2L, 1'b0, 6'd0, S_SP1, 0);
    end
    point(0, P1R, 1'b1, 6'd0, S_SP2, 0);
    point(0, P2R, 1'b1, 6'd0, S_END, 1);
    step(0, 1'b0, P1L, 10'd500, 6'd60, S_END, 8, 6, 1, 0, 0);

    $display("[TB] timeout draw on dut0");
    resetDut(0);
    for (int k = 0; k < 3; k++) begin
      point(0, P1L, 1'b1, 6'd0, S_SP2, 0);
      point(0, P2L, 1'b0, 6'd0, S_SP1, 0);
    end
    step(0, 1'b0, P1L,  10'd320, 6'd0,  S_PLAY, 3, 3, 0, 0, 0);
    step(0, 1'b0, NONE, 10'd320, 6'd59, S_PLAY, 3, 3, 0, 0, 0);
    step(0, 1'b0, NONE, 10'd320, 6'd60, S_END,  3, 3, 3, 0, 0);
    step(0, 1'b0, NONE, 10'd100, 6'd60, S_END,  3, 3, 3, 0, 0);

    $display("[TB] goal and timeout together on dut0");
    resetDut(0);
    point(0, P1L, 1'b0, 6'd60, S_END, 2);

    $display("[TB] timeout while serving on dut0");
    resetDut(0);
    step(0, 1'b0, P1L, 10'd320, 6'd60, S_END, 0, 0, 3, 0, 0);

    $display("[TB] winner serves and saturation on dut1");
    resetDut(1);
    point(1, P1L, 1'b1, 6'd0, S_SP1, 0);
    step(1, 1'b0, P2L,     10'd320, 6'd0, S_SP1, 1, 0, 0, 0, 0);
    step(1, 1'b0, P2R,     10'd320, 6'd0, S_SP1, 1, 0, 0, 0, 0);
    step(1, 1'b0, 4'b0011, 10'd320, 6'd0, S_SP1, 1, 0, 0, 0, 0);
    point(1, P1R, 1'b0, 6'd0, S_SP2, 0);
    for (int k = 2; k <= 6; k++) begin
      point(1, P2L, 1'b1, 6'd0, S_SP1, 0);
      point(1, P1L, 1'b0, 6'd0, S_SP2, 0);
    end
    point(1, P2R, 1'b1, 6'd0, S_END, 1);
    step(1, 1'b0, P2L, 10'd100, 6'd0, S_END, 7, 6, 1, 0, 0);

    $display("[TB] reset during pause on dut1");
    resetDut(1);
    step(1, 1'b0, P1L,  10'd320, 6'd0, S_PLAY,  0, 0, 0, 0, 0);
    step(1, 1'b0, NONE, 10'd500, 6'd0, S_PAUSE, 1, 0, 0, 1, 0);
    step(1, 1'b0, NONE, 10'd500, 6'd0, S_PAUSE, 1, 0, 0, 0, 0);
    step(1, 1'b1, NONE, 10'd500, 6'd0, S_SP1,   0, 0, 0, 0, 0);
    step(1, 1'b0, NONE, 10'd500, 6'd0, S_SP1,   0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
